// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan path.
// Imported by the scan controller and its prescaler.
package seg_pkg;

  localparam int NUM_DIGITS      = 8;
  localparam int DEFAULT_CLK_DIV = 100000;

  typedef logic [2:0] digit_t;
  typedef logic [3:0] nibble_t;

endpackage

// File: rtl/seg_tick_gen.sv
// Free-running prescaler; emits a one-cycle tick every CLK_DIV clocks.
// The tick is high while the counter sits at its terminal value.
module seg_tick_gen
  import seg_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int W = $clog2(CLK_DIV);
  localparam logic [W-1:0] TERM = W'(CLK_DIV - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == TERM);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Digit scan controller: walks the digit index, double-buffers the
// display word and qualifies each digit for leading-zero blanking.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] value_i,
  input  logic        load_i,
  input  logic        blank_lz_i,
  output logic [3:0]  num_o,
  output logic [2:0]  sel_o,
  output logic        digit_on_o,
  output logic        frame_o
);

  localparam digit_t LAST = digit_t'(NUM_DIGITS - 1);

  logic        tick;
  logic        wrap;
  digit_t      idx;
  logic [31:0] shadow;
  logic [31:0] vis;
  logic        pend;
  logic        frame_q;

  logic [NUM_DIGITS-1:0] lit;
  logic                  acc;

  seg_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  assign wrap = tick && (idx == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx     <= '0;
      frame_q <= 1'b0;
    end else begin
      frame_q <= wrap;
      if (tick) begin
        idx <= idx + 1'b1;
      end
    end
  end

  // A load landing on the wrap cycle goes straight to the visible word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow <= '0;
      vis    <= '0;
      pend   <= 1'b0;
    end else begin
      if (load_i) begin
        shadow <= value_i;
      end
      if (wrap) begin
        pend <= 1'b0;
        if (load_i) begin
          vis <= value_i;
        end else if (pend) begin
          vis <= shadow;
        end
      end else if (load_i) begin
        pend <= 1'b1;
      end
    end
  end

  always_comb begin
    lit = '0;
    acc = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      acc    = acc | (|vis[4*k +: 4]);
      lit[k] = acc;
    end
    lit[0] = 1'b1;
  end

  assign sel_o      = idx;
  assign num_o      = vis[{idx, 2'b00} +: 4];
  assign digit_on_o = !blank_lz_i || lit[idx];
  assign frame_o    = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with CLK_DIV = 4.
// Arithmetic reference model plus directed literal checks.
module tb_seg_scan_ctrl;

  localparam int DIV   = 4;
  localparam int FRAME = 8 * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] value_i = '0;
  logic        load_i = 1'b0;
  logic        blank_lz_i = 1'b0;
  logic [3:0]  num_o;
  logic [2:0]  sel_o;
  logic        digit_on_o;
  logic        frame_o;

  int passed = 0;
  int total  = 0;

  int          m_c = 0;
  logic [31:0] m_vis = '0;
  logic [31:0] m_sh = '0;
  logic        m_pend = 1'b0;

  seg_scan_ctrl #(
    .CLK_DIV(DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .value_i   (value_i),
    .load_i    (load_i),
    .blank_lz_i(blank_lz_i),
    .num_o     (num_o),
    .sel_o     (sel_o),
    .digit_on_o(digit_on_o),
    .frame_o   (frame_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
  endtask

  task automatic timeout(input string name);
    total++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // m_c = clock edges since reset released; slot/frame from arithmetic.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_c    = 0;
      m_vis  = '0;
      m_sh   = '0;
      m_pend = 1'b0;
    end else begin
      if (m_c % FRAME == FRAME - 1) begin
        if (load_i) m_vis = value_i;
        else if (m_pend) m_vis = m_sh;
        m_pend = 1'b0;
      end else if (load_i) begin
        m_sh   = value_i;
        m_pend = 1'b1;
      end
      m_c++;
    end
  end

  always @(posedge clk) begin
    int          s;
    logic [31:0] hi;
    #1;
    s  = (m_c / DIV) % 8;
    hi = m_vis >> (4 * s);
    chk("m_sel", int'(sel_o), s);
    chk("m_frame", int'(frame_o), int'(m_c % FRAME == 0 && m_c != 0));
    chk("m_num", int'(num_o), int'(hi[3:0]));
    chk("m_on", int'(digit_on_o),
        int'(!blank_lz_i || s == 0 || hi != 0));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_sel(input int k);
    int n = 0;
    while (int'(sel_o) != k && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeout("wait_sel");
  endtask

  task automatic wait_frame();
    int n = 0;
    @(negedge clk);
    while (frame_o !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeout("wait_frame");
  endtask

  task automatic wait_wrap();
    int n = 0;
    while (m_c % FRAME != FRAME - 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeout("wait_wrap");
  endtask

  task automatic do_load(input logic [31:0] v);
    value_i = v;
    load_i  = 1'b1;
    @(negedge clk);
    load_i  = 1'b0;
  endtask

  logic [3:0] db_exp [8] = '{4'hF, 4'hE, 4'hD, 4'hC,
                             4'hB, 4'hA, 4'h9, 4'h8};

  initial begin
    cyc(3);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_sel", int'(sel_o), 0);
    chk("rst_num", int'(num_o), 0);
    chk("rst_on", int'(digit_on_o), 1);
    chk("rst_frame", int'(frame_o), 0);
    for (int i = 1; i <= 8; i++) begin
      cyc(DIV);
      chk("step_sel", int'(sel_o), i % 8);
    end

    wait_sel(3);
    do_load(32'h89AB_CDEF);
    chk("db_hold", int'(num_o), 0);
    wait_sel(6);
    chk("db_hold6", int'(num_o), 0);
    wait_frame();
    for (int k = 0; k < 8; k++) begin
      wait_sel(k);
      chk("db_num", int'(num_o), int'(db_exp[k]));
    end

    wait_wrap();
    do_load(32'h1234_5678);
    chk("sim_sel", int'(sel_o), 0);
    chk("sim_num", int'(num_o), 8);
    chk("sim_frame", int'(frame_o), 1);
    cyc(FRAME);
    chk("sim_again", int'(num_o), 8);

    wait_sel(1);
    do_load(32'h1111_1111);
    wait_sel(4);
    do_load(32'h2222_2222);
    wait_frame();
    for (int k = 0; k < 8; k++) begin
      wait_sel(k);
      chk("llw_num", int'(num_o), 2);
    end

    blank_lz_i = 1'b1;
    do_load(32'h0000_0A05);
    wait_frame();
    for (int k = 0; k < 8; k++) begin
      wait_sel(k);
      chk("blz_a05", int'(digit_on_o), int'(k <= 2));
    end
    do_load(32'h0);
    wait_frame();
    for (int k = 0; k < 8; k++) begin
      wait_sel(k);
      chk("blz_zero", int'(digit_on_o), int'(k == 0));
    end
    blank_lz_i = 1'b0;
    wait_sel(5);
    chk("blz_off", int'(digit_on_o), 1);

    do_load(32'h7777_7777);
    wait_frame();
    wait_sel(1);
    do_load(32'hDEAD_BEEF);
    wait_sel(5);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_sel", int'(sel_o), 0);
    chk("mid_num", int'(num_o), 0);
    rst_n = 1'b1;
    cyc(2 * FRAME + 3);
    chk("mid_nopend", int'(num_o), 0);

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      load_i  = ($urandom_range(0, 19) == 0);
      value_i = $urandom >> (4 * $urandom_range(0, 8));
      if ($urandom_range(0, 63) == 0) blank_lz_i = ~blank_lz_i;
      if ($urandom_range(0, 999) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
    end
    load_i = 1'b0;
    rst_n  = 1'b1;
    cyc(4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
